// File: rtl/pi1_pkg.sv
// rtl/pi1_pkg.sv - pi1 op codes, arbiter state encoding and clog2 helper
package pi1_pkg;

  localparam logic [1:0] MEMNOOP        = 2'b00;
  localparam logic [1:0] MEMWRITEOP     = 2'b01;
  localparam logic [1:0] MEMREADOP      = 2'b10;
  localparam logic [1:0] MEMREADWRITEOP = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACTIVE = ST_ACTIVE,
    RESP   = ST_RESP
  } st_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pi1_rr_arbiter_if.sv
// rtl/pi1_rr_arbiter_if.sv - master-side and slave-side pi1 signals of the arbiter
// m_pi1_lock_i exists only when PI1ARB_LOCK_EN is defined.
interface pi1_rr_arbiter_if #(
  parameter int MASTERCOUNT = 4,
  parameter int ARCHBITSZ   = 32
);
  import pi1_pkg::*;

  localparam int SELBITSZ  = ARCHBITSZ / 8;
  localparam int ADDRBITSZ = ARCHBITSZ - clog2(SELBITSZ);

  logic [2*MASTERCOUNT-1:0]         m_pi1_op_i;
  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_pi1_addr_i;
  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_pi1_data_i;
  logic [SELBITSZ*MASTERCOUNT-1:0]  m_pi1_sel_i;
  logic [ARCHBITSZ-1:0]             m_pi1_data_o;
  logic [MASTERCOUNT-1:0]           m_pi1_rdy_o;
`ifdef PI1ARB_LOCK_EN
  logic [MASTERCOUNT-1:0]           m_pi1_lock_i;
`endif
  logic [1:0]                       s_pi1_op_o;
  logic [ADDRBITSZ-1:0]             s_pi1_addr_o;
  logic [ARCHBITSZ-1:0]             s_pi1_data_o;
  logic [SELBITSZ-1:0]              s_pi1_sel_o;
  logic [ARCHBITSZ-1:0]             s_pi1_data_i;
  logic                             s_pi1_rdy_i;

  // Arbiter view.
  modport slave (
`ifdef PI1ARB_LOCK_EN
    input  m_pi1_lock_i,
`endif
    input  m_pi1_op_i, m_pi1_addr_i, m_pi1_data_i, m_pi1_sel_i,
    output m_pi1_data_o, m_pi1_rdy_o,
    output s_pi1_op_o, s_pi1_addr_o, s_pi1_data_o, s_pi1_sel_o,
    input  s_pi1_data_i, s_pi1_rdy_i
  );

  // Surrounding system view: requesting masters plus the memory slave.
  modport master (
`ifdef PI1ARB_LOCK_EN
    output m_pi1_lock_i,
`endif
    output m_pi1_op_i, m_pi1_addr_i, m_pi1_data_i, m_pi1_sel_i,
    input  m_pi1_data_o, m_pi1_rdy_o,
    input  s_pi1_op_o, s_pi1_addr_o, s_pi1_data_o, s_pi1_sel_o,
    output s_pi1_data_i, s_pi1_rdy_i
  );

endinterface

// File: rtl/pi1_rr_pick.sv
// rtl/pi1_rr_pick.sv - rotate-priority encoder: first set req bit after ptr, modulo N
module pi1_rr_pick
  import pi1_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [N-1:0] rot;
  int           off;

  always_comb begin
    // bit k of rot is master (ptr+1+k) mod N
    rot   = N'({req, req} >> (int'(ptr) + 1));
    valid = |rot;
    off   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    off = off + int'(ptr) + 1;
    if (off >= N) off = off - N;
    idx = IW'(off);
  end

endmodule

// File: rtl/pi1_rr_arbiter.sv
// rtl/pi1_rr_arbiter.sv - round-robin arbiter sharing one pi1 slave port among MASTERCOUNT masters
// Define PI1ARB_LOCK_EN to add m_pi1_lock_i grant holding.
module pi1_rr_arbiter
  import pi1_pkg::*;
#(
  parameter int MASTERCOUNT = 4,
  parameter int ARCHBITSZ   = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  pi1_rr_arbiter_if.slave bus
);

  localparam int SELBITSZ  = ARCHBITSZ / 8;
  localparam int ADDRBITSZ = ARCHBITSZ - clog2(SELBITSZ);
  localparam int IDXW      = clog2(MASTERCOUNT);

  st_t                  st, st_nxt;
  logic [IDXW-1:0]      gnt, gnt_nxt;
  logic [IDXW-1:0]      ptr, ptr_nxt;
  logic [MASTERCOUNT-1:0] req;
  logic                 pick_valid;
  logic [IDXW-1:0]      pick_idx;
  logic                 done;
  logic [1:0]           g_op;
  logic [ADDRBITSZ-1:0] g_addr;
  logic [ARCHBITSZ-1:0] g_data;
  logic [SELBITSZ-1:0]  g_sel;
`ifdef PI1ARB_LOCK_EN
  logic                 held, held_nxt;
`endif

  always_comb begin
    req = '0;
    for (int i = 0; i < MASTERCOUNT; i++) begin
      req[i] = (bus.m_pi1_op_i[2*i +: 2] != MEMNOOP);
    end
  end

  pi1_rr_pick #(
    .N  (MASTERCOUNT),
    .IW (IDXW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Forwarded request is selected by the registered gnt only, never by the picker.
  always_comb begin
    g_op   = MEMNOOP;
    g_addr = '0;
    g_data = '0;
    g_sel  = '0;
    for (int i = 0; i < MASTERCOUNT; i++) begin
      if (gnt == IDXW'(i)) begin
        g_op   = bus.m_pi1_op_i[2*i +: 2];
        g_addr = bus.m_pi1_addr_i[ADDRBITSZ*i +: ADDRBITSZ];
        g_data = bus.m_pi1_data_i[ARCHBITSZ*i +: ARCHBITSZ];
        g_sel  = bus.m_pi1_sel_i[SELBITSZ*i +: SELBITSZ];
      end
    end
  end

  assign bus.m_pi1_data_o = bus.s_pi1_data_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st   <= IDLE;
      gnt  <= '0;
      ptr  <= IDXW'(MASTERCOUNT - 1);
`ifdef PI1ARB_LOCK_EN
      held <= 1'b0;
`endif
    end else begin
      st   <= st_nxt;
      gnt  <= gnt_nxt;
      ptr  <= ptr_nxt;
`ifdef PI1ARB_LOCK_EN
      held <= held_nxt;
`endif
    end
  end

  always_comb begin
    st_nxt           = st;
    gnt_nxt          = gnt;
    ptr_nxt          = ptr;
    done             = 1'b0;
`ifdef PI1ARB_LOCK_EN
    held_nxt         = held;
`endif
    bus.s_pi1_op_o   = MEMNOOP;
    bus.s_pi1_addr_o = '0;
    bus.s_pi1_data_o = '0;
    bus.s_pi1_sel_o  = '0;
    bus.m_pi1_rdy_o  = '0;

    case (st)
      IDLE: begin
`ifdef PI1ARB_LOCK_EN
        held_nxt = 1'b0;
        if (held && req[gnt]) begin
          st_nxt = ACTIVE;
        end else
`endif
        if (pick_valid) begin
          gnt_nxt = pick_idx;
          st_nxt  = ACTIVE;
        end
      end

      ACTIVE: begin
        bus.s_pi1_op_o       = g_op;
        bus.s_pi1_addr_o     = g_addr;
        bus.s_pi1_data_o     = g_data;
        bus.s_pi1_sel_o      = g_sel;
        bus.m_pi1_rdy_o[gnt] = bus.s_pi1_rdy_i;
        if (g_op == MEMNOOP) begin
          // master withdrew before acceptance; release the port rather than hang
          done = 1'b1;
        end else if (bus.s_pi1_rdy_i) begin
          case (g_op)
            MEMWRITEOP:                done   = 1'b1;
            MEMREADOP, MEMREADWRITEOP: st_nxt = RESP;
            default:                   done   = 1'b1;
          endcase
        end
      end

      RESP: begin
        bus.m_pi1_rdy_o[gnt] = bus.s_pi1_rdy_i;
        if (bus.s_pi1_rdy_i) done = 1'b1;
      end

      default: st_nxt = IDLE;
    endcase

    if (done) begin
      st_nxt = IDLE;
`ifdef PI1ARB_LOCK_EN
      if (bus.m_pi1_lock_i[gnt]) held_nxt = 1'b1;
      else                       ptr_nxt  = gnt;
`else
      ptr_nxt = gnt;
`endif
    end
  end

endmodule

// File: tb/tb_pi1_rr_arbiter.sv
// tb/tb_pi1_rr_arbiter.sv - directed and randomized-batch bench for pi1_rr_arbiter
// Lock scenario runs only when PI1ARB_LOCK_EN is defined.
module tb_pi1_rr_arbiter;
  import pi1_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int AW = DW - 2;

  logic clk   = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  pi1_rr_arbiter_if #(.MASTERCOUNT(N), .ARCHBITSZ(DW)) bus ();

  pi1_rr_arbiter #(.MASTERCOUNT(N), .ARCHBITSZ(DW)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // behavioural master/slave state
  int          left  [N];
  int          ph    [N];   // 0 free, 1 request held, 2 awaiting read data
  logic [1:0]  t_op  [N];
  logic [AW-1:0] t_addr[N];
  logic [DW-1:0] t_data[N];
  logic [SW-1:0] t_sel [N];
  int          glog[$];
  int          exp_q[$];
  bit          lock_mode = 1'b0;
  int          idle_run  = 0;
  int          last;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
    bus.m_pi1_op_i[2*i +: 2]     = op;
    bus.m_pi1_addr_i[AW*i +: AW] = a;
    bus.m_pi1_data_i[DW*i +: DW] = d;
    bus.m_pi1_sel_i[SW*i +: SW]  = s;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_m(i, MEMNOOP, '0, '0, '0);
`ifdef PI1ARB_LOCK_EN
    bus.m_pi1_lock_i = '0;
`endif
    bus.s_pi1_rdy_i = 1'b0;
  endtask

  task automatic quiet();
    tick();
    clear_all();
    smp();
  endtask

  task automatic step();
    logic [DW-1:0] sd;
    bit any_req;
    bit any_wait;
    tick();
    for (int i = 0; i < N; i++) begin
      if (ph[i] == 0 && left[i] > 0) begin
        t_op[i]   = lock_mode ? MEMREADOP : 2'($urandom_range(1, 3));
        t_addr[i] = AW'($urandom);
        t_data[i] = $urandom;
        t_sel[i]  = SW'($urandom);
        ph[i]     = 1;
      end
      if (ph[i] == 1) set_m(i, t_op[i], t_addr[i], t_data[i], t_sel[i]);
      else            set_m(i, MEMNOOP, '0, '0, '0);
`ifdef PI1ARB_LOCK_EN
      bus.m_pi1_lock_i[i] = lock_mode && (left[i] > 1);
`endif
    end
    sd = $urandom;
    bus.s_pi1_rdy_i  = ($urandom_range(0, 3) != 0);
    bus.s_pi1_data_i = sd;
    smp();
    any_req  = 1'b0;
    any_wait = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ph[i] == 1) any_req  = 1'b1;
      if (ph[i] == 2) any_wait = 1'b1;
    end
    chk("rdy_any", |bus.m_pi1_rdy_o,
        bus.s_pi1_rdy_i && (bus.s_pi1_op_o != MEMNOOP || any_wait));
    chk("rdy_onehot", $countones(bus.m_pi1_rdy_o) <= 1, 1);
    if (!any_wait && any_req && bus.s_pi1_op_o == MEMNOOP) begin
      idle_run++;
      chk("arb_latency", idle_run <= 1, 1);
    end else begin
      idle_run = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.m_pi1_rdy_o[i]) begin
        if (ph[i] == 1) begin
          chk("acc_op", bus.s_pi1_op_o, t_op[i]);
          chk("acc_addr", bus.s_pi1_addr_o, t_addr[i]);
          chk("acc_data", bus.s_pi1_data_o, t_data[i]);
          chk("acc_sel", bus.s_pi1_sel_o, t_sel[i]);
          glog.push_back(i);
          if (t_op[i] == MEMWRITEOP) begin
            ph[i] = 0;
            left[i]--;
          end else begin
            ph[i] = 2;
          end
        end else if (ph[i] == 2) begin
          chk("rd_data", bus.m_pi1_data_o, sd);
          ph[i] = 0;
          left[i]--;
        end else begin
          chk("rdy_stray", 64'(i), 64'hFF);
        end
      end
    end
  endtask

  task automatic run(input int budget);
    int  cyc;
    bit  busy;
    cyc = 0;
    forever begin
      busy = 1'b0;
      for (int i = 0; i < N; i++) if (left[i] > 0 || ph[i] != 0) busy = 1'b1;
      if (!busy) break;
      if (cyc >= budget) begin
        chk("timeout", 64'(cyc), 64'(budget - 1));
        for (int i = 0; i < N; i++) begin
          left[i] = 0;
          ph[i]   = 0;
        end
        break;
      end
      step();
      cyc++;
    end
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_len"}, 64'(glog.size()), 64'(exp_q.size()));
    for (int k = 0; k < glog.size() && k < exp_q.size(); k++) begin
      chk(tag, 64'(glog[k]), 64'(exp_q[k]));
    end
  endtask

  task automatic do_reset();
    tick();
    rst_i = 1'b0;
    clear_all();
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  initial begin
    int mask;
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      ph[i]   = 0;
    end
    clear_all();
    bus.s_pi1_data_i = '0;

    // reset state
    repeat (2) @(posedge clk);
    smp();
    chk("rst_op", bus.s_pi1_op_o, MEMNOOP);
    chk("rst_addr", bus.s_pi1_addr_o, 0);
    chk("rst_data", bus.s_pi1_data_o, 0);
    chk("rst_sel", bus.s_pi1_sel_o, 0);
    chk("rst_rdy", bus.m_pi1_rdy_o, 0);
    tick();
    rst_i = 1'b1;

    // single write from master 2
    tick();
    set_m(2, MEMWRITEOP, 30'h10, 32'hDEADBEEF, 4'hF);
    bus.s_pi1_rdy_i = 1'b1;
    smp();
    chk("w_idle_op", bus.s_pi1_op_o, MEMNOOP);
    chk("w_idle_rdy", bus.m_pi1_rdy_o, 0);
    tick();
    smp();
    chk("w_op", bus.s_pi1_op_o, MEMWRITEOP);
    chk("w_addr", bus.s_pi1_addr_o, 30'h10);
    chk("w_data", bus.s_pi1_data_o, 32'hDEADBEEF);
    chk("w_sel", bus.s_pi1_sel_o, 4'hF);
    chk("w_rdy", bus.m_pi1_rdy_o, 4'b0100);
    tick();
    set_m(2, MEMNOOP, '0, '0, '0);
    smp();
    chk("w_after_op", bus.s_pi1_op_o, MEMNOOP);
    chk("w_after_rdy", bus.m_pi1_rdy_o, 0);

    // read from master 1 with a 3-cycle wait
    tick();
    set_m(1, MEMREADOP, 30'h20, '0, 4'hF);
    smp();
    chk("r_idle_rdy", bus.m_pi1_rdy_o, 0);
    tick();
    smp();
    chk("r_op", bus.s_pi1_op_o, MEMREADOP);
    chk("r_acc_rdy", bus.m_pi1_rdy_o, 4'b0010);
    tick();
    set_m(1, MEMNOOP, '0, '0, '0);
    bus.s_pi1_rdy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.s_pi1_data_i = $urandom;
      smp();
      chk("r_wait_rdy", bus.m_pi1_rdy_o, 0);
      chk("r_wait_op", bus.s_pi1_op_o, MEMNOOP);
      tick();
    end
    bus.s_pi1_rdy_i  = 1'b1;
    bus.s_pi1_data_i = 32'h12345678;
    smp();
    chk("r_data_rdy", bus.m_pi1_rdy_o, 4'b0010);
    chk("r_data", bus.m_pi1_data_o, 32'h12345678);
    tick();
    smp();
    chk("r_after_rdy", bus.m_pi1_rdy_o, 0);

    // rotation after reset with all masters requesting
    do_reset();
    left[0] = 2; left[1] = 1; left[2] = 1; left[3] = 1;
    glog.delete();
    exp_q = '{0, 1, 2, 3, 0};
    run(200);
    cmp_log("rot_order");
    quiet();

    // reset during read response wait
    tick();
    set_m(2, MEMREADOP, 30'h3, '0, 4'h1);
    bus.s_pi1_rdy_i = 1'b1;
    smp();
    tick();
    smp();
    chk("rr_acc", bus.m_pi1_rdy_o, 4'b0100);
    tick();
    set_m(2, MEMNOOP, '0, '0, '0);
    bus.s_pi1_rdy_i = 1'b0;
    smp();
    chk("rr_wait", bus.m_pi1_rdy_o, 0);
    bus.s_pi1_rdy_i = 1'b1;
    #1;
    chk("rr_pre", bus.m_pi1_rdy_o, 4'b0100);
    rst_i = 1'b0;
    #1;
    chk("rr_async_rdy", bus.m_pi1_rdy_o, 0);
    chk("rr_async_op", bus.s_pi1_op_o, MEMNOOP);
    chk("rr_async_addr", bus.s_pi1_addr_o, 0);
    tick();
    bus.s_pi1_rdy_i = 1'b0;
    tick();
    rst_i = 1'b1;
    set_m(0, MEMWRITEOP, 30'h5, 32'h5, 4'h3);
    set_m(3, MEMWRITEOP, 30'h6, 32'h6, 4'hC);
    bus.s_pi1_rdy_i = 1'b1;
    smp();
    chk("rr_idle", bus.m_pi1_rdy_o, 0);
    tick();
    smp();
    chk("rr_first_gnt", bus.m_pi1_rdy_o, 4'b0001);
    tick();
    set_m(0, MEMNOOP, '0, '0, '0);
    set_m(3, MEMNOOP, '0, '0, '0);
    smp();
    chk("rr_done", bus.m_pi1_rdy_o, 0);

    // master 3 withdraws while ACTIVE
    tick();
    set_m(3, MEMWRITEOP, 30'h7, 32'h7, 4'hF);
    bus.s_pi1_rdy_i = 1'b0;
    smp();
    chk("drop_idle", bus.s_pi1_op_o, MEMNOOP);
    tick();
    smp();
    chk("drop_active_op", bus.s_pi1_op_o, MEMWRITEOP);
    chk("drop_active_rdy", bus.m_pi1_rdy_o, 0);
    tick();
    set_m(3, MEMNOOP, '0, '0, '0);
    smp();
    chk("drop_rdy", bus.m_pi1_rdy_o, 0);
    tick();
    set_m(0, MEMWRITEOP, 30'h8, 32'h8, 4'hF);
    set_m(1, MEMWRITEOP, 30'h9, 32'h9, 4'hF);
    bus.s_pi1_rdy_i = 1'b1;
    smp();
    chk("drop_back_idle_op", bus.s_pi1_op_o, MEMNOOP);
    chk("drop_back_idle_rdy", bus.m_pi1_rdy_o, 0);
    tick();
    smp();
    chk("drop_next_gnt", bus.m_pi1_rdy_o, 4'b0001);
    tick();
    set_m(0, MEMNOOP, '0, '0, '0);
    smp();
    chk("drop_gap", bus.m_pi1_rdy_o, 0);
    tick();
    smp();
    chk("drop_second_gnt", bus.m_pi1_rdy_o, 4'b0010);
    tick();
    set_m(1, MEMNOOP, '0, '0, '0);
    smp();
    last = 1;

    // randomized batches: simultaneous requesters served in rotation from last+1
    for (int b = 0; b < 40; b++) begin
      mask = $urandom_range(1, (1 << N) - 1);
      glog.delete();
      exp_q.delete();
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (last + k) % N;
        if (mask[j]) begin
          left[j] = 1;
          exp_q.push_back(j);
        end
      end
      run(400);
      cmp_log("batch_order");
      last = exp_q[exp_q.size() - 1];
      quiet();
    end

`ifdef PI1ARB_LOCK_EN
    left[0] = 1;
    run(100);
    quiet();
    glog.delete();
    lock_mode = 1'b1;
    left[1] = 3;
    left[2] = 1;
    exp_q = '{1, 1, 1, 2};
    run(300);
    cmp_log("lock_order");
    lock_mode = 1'b0;
    quiet();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pi1_rr_arbiter.md
# pi1_rr_arbiter

Round-robin arbiter that shares one pi1 memory port between `MASTERCOUNT` requesting masters, such as several `pu` instances or a `pu` plus DMA. It sits between the masters' `pi1_*` ports and the single downstream slave port (memory controller or interconnect). It owns the whole transaction sequence: grant, request acceptance and, for reads, the data-return phase. It guarantees exactly one master drives the slave at any time.

## Interface
- `MASTERCOUNT`, 4: number of masters; minimum 2.
- `ARCHBITSZ`, 32: data width.
- `ADDRBITSZ`, `ARCHBITSZ-clog2(ARCHBITSZ/8)`: word address width (local param).
- `clk_i` in 1: clock; all state on rising edge.
- `rst_i` in 1: reset, asynchronous assert, active-low.
- `m_pi1_op_i` in `2*MASTERCOUNT`: per-master op: MEMNOOP=00, MEMWRITEOP=01, MEMREADOP=10, MEMREADWRITEOP=11.
- `m_pi1_addr_i` in `ADDRBITSZ*MASTERCOUNT`: per-master word address.
- `m_pi1_data_i` in `ARCHBITSZ*MASTERCOUNT`: per-master write data.
- `m_pi1_sel_i` in `(ARCHBITSZ/8)*MASTERCOUNT`: per-master byte select.
- `m_pi1_data_o` out `ARCHBITSZ`: read data, broadcast to all masters.
- `m_pi1_rdy_o` out `MASTERCOUNT`: per-master ready.
- `m_pi1_lock_i` in `MASTERCOUNT`: hold-grant request. Present only with `PI1ARB_LOCK_EN`.
- `s_pi1_op_o` out 2: slave op.
- `s_pi1_addr_o` out `ADDRBITSZ`: slave address.
- `s_pi1_data_o` out `ARCHBITSZ`: slave write data.
- `s_pi1_sel_o` out `ARCHBITSZ/8`: slave byte select.
- `s_pi1_data_i` in `ARCHBITSZ`: slave read data.
- `s_pi1_rdy_i` in 1: slave ready.

## Operation
- pi1 protocol:
  - A request is accepted in the cycle where op≠MEMNOOP and `rdy` is high.
  - For MEMREADOP and MEMREADWRITEOP, read data is valid on the first later cycle with `rdy` high.
  - A master holds op/addr/data/sel stable until acceptance.
- State machine `st`:
  - IDLE: drive `s_pi1_op_o`=MEMNOOP. If any master has op≠MEMNOOP, pick the first requester scanning from `ptr+1` modulo `MASTERCOUNT`, register it in `gnt`, then go to ACTIVE. Otherwise stay in IDLE.
  - ACTIVE: forward `gnt`'s op/addr/data/sel to the slave, and `m_pi1_rdy_o[gnt]`=`s_pi1_rdy_i`.
    - On acceptance of MEMWRITEOP: set `ptr`←`gnt`, go to IDLE.
    - On acceptance of a read-type op: go to RESP.
    - If `gnt`'s op drops to MEMNOOP before acceptance: set `ptr`←`gnt`, go to IDLE. This is a protocol violation, tolerated without hang.
  - RESP: `s_pi1_op_o`=MEMNOOP, `m_pi1_data_o`=`s_pi1_data_i`, `m_pi1_rdy_o[gnt]`=`s_pi1_rdy_i`. When `s_pi1_rdy_i` is high, set `ptr`←`gnt` and go to IDLE.
- Non-granted masters always see `m_pi1_rdy_o`=0. In IDLE every bit of `m_pi1_rdy_o` is 0.
- `m_pi1_data_o` = `s_pi1_data_i` in all states. Masters qualify it with their own rdy.
- Fairness: with all masters requesting continuously, grants rotate 0,1,…,`MASTERCOUNT-1`,0. A waiting master is served within `MASTERCOUNT-1` foreign transactions.
- Simultaneous events: a new request arriving during ACTIVE or RESP is not considered until the next IDLE. A slave `rdy` high in IDLE is ignored.
- Reset, including mid-transaction:
  - `st`=IDLE, `gnt`=0, `ptr`=`MASTERCOUNT-1`, so master 0 has priority first.
  - Slave outputs go to MEMNOOP, all-zero addr/data/sel. `m_pi1_rdy_o`=0.
  - An in-flight slave transaction is abandoned; the slave is reset by the same `rst_i`.

## Timing
- Arbitration: 1 cycle (IDLE). A request first appears at the slave the cycle after it is first seen.
- Write cost: 1 (IDLE) + N (ACTIVE until `rdy`). Best case 2 cycles per write.
- Read cost: 1 + acceptance + response. Best case 3 cycles.
- The slave op/addr/data/sel outputs and `m_pi1_rdy_o` are combinational from `st`/`gnt`/`s_pi1_rdy_i`. This is a single mux level, with no path from `m_pi1_op_i` to `s_pi1_op_o` through the selector.
- Reset values: all outputs 0; `s_pi1_op_o`=MEMNOOP.

## Configuration
- `PI1ARB_LOCK_EN` defined:
  - Adds the `m_pi1_lock_i` port.
  - On completion (the transition to IDLE) with `m_pi1_lock_i[gnt]` high, `ptr` is not updated and `gnt` is kept. The next IDLE grants `gnt` first if it is requesting.
  - Lock is sampled only at completion.
  - A locked master that stops requesting loses the grant by normal rotation.
- Not defined: no lock port, pure round-robin.

## Structure
- Shared package `pi1_pkg`: `MEMNOOP`/`MEMWRITEOP`/`MEMREADOP`/`MEMREADWRITEOP` constants, a state encoding localparam for IDLE/ACTIVE/RESP, and `clog2`.
- One sub-module `pi1_rr_pick`: combinational rotate-priority encoder. Inputs are the request vector and `ptr`; outputs are `valid` and `idx`.

## Test plan
- Single write:
  - Stimulus: master 2 issues MEMWRITEOP, addr 0x10, data 0xDEADBEEF, sel 0xF; slave `rdy` constantly 1.
  - Response: slave sees it exactly 1 cycle later for 1 cycle; `m_pi1_rdy_o`=0b0100 that cycle; back to IDLE.
- Read with wait:
  - Stimulus: master 1 issues MEMREADOP; slave accepts, then holds `rdy`=0 for 3 cycles, then returns 0x12345678.
  - Response: `m_pi1_rdy_o[1]` high only on accept and on data cycles; data 0x12345678 matches.
- Rotation: all 4 masters hold writes after reset → grant order 0,1,2,3,0; no master served twice before all others.
- Reset mid-RESP: deassert-then-assert `rst_i` during a read wait → outputs zero immediately (asynchronously); the first grant after release goes to master 0.
- Dropped request: master 3 drops its op while ACTIVE with slave `rdy`=0 → IDLE next cycle; `ptr`=3; the next grant goes to master 0.
- With `PI1ARB_LOCK_EN`:
  - Stimulus: master 1 does 3 reads with lock high, master 2 requesting.
  - Response: master 1 is served 3 times consecutively; master 2 is granted after lock is low at a completion.
